// File: rtl/path_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : path_buffer_if
// Purpose  : Bundles the control, push/pop and replay-stream signals of
//            path_buffer. The slave modport is the buffer side; the master
//            modport is the solver/consumer side.
// Signals  : clear, push, push_data, pop, start_replay, replay_dir,
//            out_ready (master -> slave)
//            top_data, out_valid, out_data, count, empty, full, overflow,
//            underflow, replaying, replay_done (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface path_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clear;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] top_data;
  logic              start_replay;
  logic              replay_dir;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic              replaying;
  logic              replay_done;

  modport slave (
    input  clear, push, push_data, pop, start_replay, replay_dir, out_ready,
    output top_data, out_valid, out_data, count, empty, full, overflow,
           underflow, replaying, replay_done
  );

  modport master (
    output clear, push, push_data, pop, start_replay, replay_dir, out_ready,
    input  top_data, out_valid, out_data, count, empty, full, overflow,
           underflow, replaying, replay_done
  );
endinterface
`default_nettype wire

// File: rtl/path_buffer.sv
`default_nettype none
// ============================================================================
// Module   : path_buffer
// Purpose  : Path store for the route solver. Acts as a backtracking stack
//            while building (BUILD), then replays the stored entries over a
//            valid/ready stream oldest- or newest-first (REPLAY). Contents
//            survive replay so the path can be replayed again from DONE.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-high reset
//            bus - path_buffer_if.slave (control, stack and stream signals)
// Revision : 1.0 - initial release
// ============================================================================
module path_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  wire logic     clk,
  input  wire logic     rst,
  path_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_BUILD  = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_dir;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_replay_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_build_op;
  logic              w_replace;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_addr;
  logic [PTR_W-1:0]  w_first_ptr;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_xfer;
  logic              w_last;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // When full the low bits of count wrap to 0, so count-1 still lands on
  // DEPTH-1, the correct top index.
  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top_idx = w_wr_idx - PTR_W'(1);

  // Stack operations only happen in BUILD, and start_replay wins over them.
  assign w_build_op = (r_state == ST_BUILD) && !bus.clear && !bus.start_replay;
  // push+pop on a non-empty stack overwrites the top; on an empty stack the
  // pop is dropped and it behaves as a plain push.
  assign w_replace  = w_build_op && bus.push && bus.pop && !w_empty;
  assign w_wr_en    = w_build_op && bus.push && (w_replace || !w_full);
  assign w_wr_addr  = w_replace ? w_top_idx : w_wr_idx;

  assign w_first_ptr = bus.replay_dir ? w_top_idx : '0;
  assign w_next_ptr  = r_dir ? (r_rd_ptr - PTR_W'(1)) : (r_rd_ptr + PTR_W'(1));
  assign w_xfer      = (r_state == ST_REPLAY) && r_out_valid && bus.out_ready;
  assign w_last      = r_dir ? (r_rd_ptr == '0) : (r_rd_ptr == w_top_idx);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= bus.push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BUILD;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_dir         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_replay_done <= 1'b0;
    end else begin
      r_replay_done <= 1'b0;
      if (bus.clear) begin
        r_state     <= ST_BUILD;
        r_count     <= '0;
        r_rd_ptr    <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        case (r_state)
          ST_BUILD, ST_DONE: begin
            if (bus.start_replay) begin
              r_dir <= bus.replay_dir;
              if (!w_empty) begin
                r_state     <= ST_REPLAY;
                r_rd_ptr    <= w_first_ptr;
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[w_first_ptr];
              end else begin
                r_state       <= ST_DONE;
                r_replay_done <= 1'b1;
              end
            end else if (r_state == ST_BUILD) begin
              if (w_replace) begin
                r_count <= r_count;
              end else if (bus.push) begin
                if (!w_full) r_count    <= r_count + CNT_W'(1);
                else         r_overflow <= 1'b1;
              end else if (bus.pop) begin
                if (!w_empty) r_count     <= r_count - CNT_W'(1);
                else          r_underflow <= 1'b1;
              end
            end
          end
          ST_REPLAY: begin
            if (w_xfer) begin
              if (w_last) begin
                r_out_valid   <= 1'b0;
                r_state       <= ST_DONE;
                r_replay_done <= 1'b1;
              end else begin
                // Advance and prefetch on the same edge so a held-high
                // ready streams one entry per cycle.
                r_rd_ptr   <= w_next_ptr;
                r_out_data <= r_mem[w_next_ptr];
              end
            end
          end
          default: r_state <= ST_BUILD;
        endcase
      end
    end
  end

  assign bus.top_data    = w_empty ? '0 : r_mem[w_top_idx];
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.count       = r_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.replaying   = (r_state == ST_REPLAY);
  assign bus.replay_done = r_replay_done;
endmodule
`default_nettype wire

// File: tb/tb_path_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_buffer
// Purpose  : Self-checking bench for path_buffer (DEPTH = 4, DATA_W = 8).
//            A queue-based reference model is compared against every output
//            on each falling edge; directed steps add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_path_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;

  path_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  path_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  int         m_mode  = 0;     // 0 build, 1 replay, 2 done
  bit         m_dir   = 0;
  int         m_idx   = 0;     // entries already transferred
  bit         m_valid = 0;
  logic [7:0] m_data  = 8'h00;
  bit         m_ov    = 0;
  bit         m_un    = 0;
  bit         m_rd    = 0;

  function automatic logic [7:0] m_elem(input int k);
    return m_dir ? m_q[m_q.size() - 1 - k] : m_q[k];
  endfunction

  task m_reset();
    m_q.delete();
    m_mode = 0; m_idx = 0; m_valid = 0; m_data = 8'h00;
    m_ov = 0; m_un = 0; m_rd = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      m_rd = 0;
      if (bus.clear) begin
        m_reset();
      end else if (m_mode != 1 && bus.start_replay) begin
        m_dir = bus.replay_dir;
        if (m_q.size() > 0) begin
          m_mode = 1; m_idx = 0; m_valid = 1; m_data = m_elem(0);
        end else begin
          m_mode = 2; m_rd = 1;
        end
      end else if (m_mode == 0) begin
        if (bus.push && bus.pop && m_q.size() > 0) m_q[m_q.size() - 1] = bus.push_data;
        else if (bus.push) begin
          if (m_q.size() < DEPTH) m_q.push_back(bus.push_data);
          else m_ov = 1;
        end else if (bus.pop) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
          else m_un = 1;
        end
      end else if (m_mode == 1) begin
        if (m_valid && bus.out_ready) begin
          m_idx++;
          if (m_idx == m_q.size()) begin
            m_valid = 0; m_mode = 2; m_rd = 1;
          end else begin
            m_data = m_elem(m_idx);
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [7:0] got[$];
  int         n_done = 0;

  always @(negedge clk) begin
    chk("count",       bus.count,       m_q.size());
    chk("empty",       bus.empty,       m_q.size() == 0);
    chk("full",        bus.full,        m_q.size() == DEPTH);
    chk("top_data",    bus.top_data,    (m_q.size() > 0) ? m_q[m_q.size() - 1] : 8'h00);
    chk("out_valid",   bus.out_valid,   m_valid);
    chk("out_data",    bus.out_data,    m_data);
    chk("overflow",    bus.overflow,    m_ov);
    chk("underflow",   bus.underflow,   m_un);
    chk("replaying",   bus.replaying,   m_mode == 1);
    chk("replay_done", bus.replay_done, m_rd);
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.replay_done) n_done++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.clear = 0; bus.push = 0; bus.pop = 0; bus.push_data = 8'h00;
    bus.start_replay = 0; bus.replay_dir = 0;
  endtask

  task automatic do_push(input logic [7:0] d);
    bus.push = 1; bus.push_data = d; step(); idle();
  endtask

  task automatic do_pop();
    bus.pop = 1; step(); idle();
  endtask

  task automatic do_clear();
    bus.clear = 1; step(); idle();
  endtask

  task automatic chk_stream(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] g0, g1;
    g0 = (got.size() > 0) ? got[0] : 8'hxx;
    g1 = (got.size() > 1) ? got[1] : 8'hxx;
    chk({name, "_len"}, got.size(), 2);
    chk({name, "_0"}, g0, a);
    chk({name, "_1"}, g1, b);
  endtask

  initial begin
    rst = 1; idle(); bus.out_ready = 0;
    #12 rst = 0;
    step();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_top",   bus.top_data, 8'h00);

    // stack push/pop
    do_push(8'h11); do_push(8'h23); do_push(8'h35);
    chk("push3_count", bus.count, 3);
    chk("push3_top",   bus.top_data, 8'h35);
    do_pop();
    chk("pop_count", bus.count, 2);
    chk("pop_top",   bus.top_data, 8'h23);
    chk("pop_uf",    bus.underflow, 0);

    // replace top
    bus.push = 1; bus.pop = 1; bus.push_data = 8'h44; step(); idle();
    chk("repl_count", bus.count, 2);
    chk("repl_top",   bus.top_data, 8'h44);

    // underflow, sticky, cleared by clear
    do_pop(); do_pop(); do_pop();
    chk("uf_set", bus.underflow, 1);
    step();
    chk("uf_sticky", bus.underflow, 1);
    // push+pop on empty acts as push, no underflow change
    bus.push = 1; bus.pop = 1; bus.push_data = 8'h66; step(); idle();
    chk("pp_empty_count", bus.count, 1);
    do_clear();
    chk("clr_uf",    bus.underflow, 0);
    chk("clr_count", bus.count, 0);

    // overflow at DEPTH = 4
    do_push(8'h01); do_push(8'h02); do_push(8'h03); do_push(8'h04); do_push(8'h05);
    chk("ovf_full",  bus.full, 1);
    chk("ovf_count", bus.count, 4);
    chk("ovf_flag",  bus.overflow, 1);
    chk("ovf_top",   bus.top_data, 8'h04);
    // push+pop while full replaces top, no flag change
    bus.push = 1; bus.pop = 1; bus.push_data = 8'h0A; step(); idle();
    chk("full_repl_top", bus.top_data, 8'h0A);
    do_clear();

    // start_replay on empty: straight to DONE with a pulse
    bus.start_replay = 1; step(); idle();
    chk("empty_rd_pulse", bus.replay_done, 1);
    chk("empty_rd_valid", bus.out_valid, 0);
    do_clear();

    // replay oldest-first, ready held
    do_push(8'h11); do_push(8'h44);
    got.delete(); n_done = 0;
    bus.out_ready = 1; bus.start_replay = 1; bus.replay_dir = 0; step(); idle();
    chk("r0_valid0", bus.out_valid, 1);
    chk("r0_data0",  bus.out_data, 8'h11);
    step();
    chk("r0_data1",  bus.out_data, 8'h44);
    step();
    chk("r0_end_valid", bus.out_valid, 0);
    chk("r0_end_done",  bus.replay_done, 1);
    chk("r0_hold",      bus.out_data, 8'h44);
    step(); step();
    chk_stream("r0", 8'h11, 8'h44);
    chk("r0_pulses", n_done, 1);

    // replay newest-first with stalls; push ignored during replay
    got.delete(); n_done = 0;
    bus.start_replay = 1; bus.replay_dir = 1; step(); idle();
    chk("r1_data0", bus.out_data, 8'h44);
    bus.out_ready = 1; step();
    chk("r1_data1", bus.out_data, 8'h11);
    bus.out_ready = 0; bus.push = 1; bus.push_data = 8'h99; step();
    chk("r1_stall1", bus.out_data, 8'h11);
    step(); idle();
    chk("r1_stall2", bus.out_data, 8'h11);
    chk("r1_valid",  bus.out_valid, 1);
    bus.out_ready = 1; step();
    chk("r1_end_done", bus.replay_done, 1);
    step(); step();
    chk_stream("r1", 8'h44, 8'h11);
    chk("r1_pulses", n_done, 1);
    chk("r1_count",  bus.count, 2);

    // replay again from DONE, oldest-first
    got.delete();
    bus.start_replay = 1; bus.replay_dir = 0; step(); idle();
    step(); step(); step();
    chk_stream("r2", 8'h11, 8'h44);

    // asynchronous reset in the middle of a replay
    bus.out_ready = 0; bus.start_replay = 1; bus.replay_dir = 0; step(); idle();
    chk("ar_pre_valid", bus.out_valid, 1);
    #1 rst = 1;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_data",  bus.out_data, 8'h00);
    chk("ar_count", bus.count, 0);
    chk("ar_repl",  bus.replaying, 0);
    step();
    rst = 0;
    step();
    do_push(8'h5A);
    chk("ar_build_push", bus.top_data, 8'h5A);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
